pattern_scan_ctrl: RTL

//   Sequencer for a serial pattern detector (default pattern 10010, overlapping detection).

---
 rtl/pattern_scan_ctrl_if.sv | 24 ++
 rtl/pattern_scan_ctrl.sv | 109 ++++++++++
 2 files changed

// File: rtl/pattern_scan_ctrl_if.sv
// Word/report handshake bundle for pattern_scan_ctrl.
// master = requester/consumer side, slave = controller side.
interface pattern_scan_ctrl_if #(
    parameter int unsigned WORD_W = 8,
    parameter int unsigned CNT_W  = 4
);
    logic              in_valid;
    logic              in_ready;
    logic [WORD_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [CNT_W-1:0]  out_count;
    logic              out_hit;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_count, out_hit
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_count, out_hit
    );
endinterface

// File: rtl/pattern_scan_ctrl.sv
// Word-serial pattern detector sequencer: accepts a word, shifts it MSB-first
// through a detector with persistent history, and reports the per-word match count.
module pattern_scan_ctrl #(
    parameter int unsigned      WORD_W = 8,
    parameter int unsigned      PAT_W  = 5,
    parameter logic [PAT_W-1:0] PAT    = 5'b10010,
    parameter int unsigned      CNT_W  = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               overlap,
    pattern_scan_ctrl_if.slave bus,
    output logic               busy,
    output logic [1:0]         cstate
);
    localparam int unsigned         IDX_W     = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam int unsigned         FILL_W    = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0]   FILL_FULL = FILL_W'(PAT_W);
    localparam logic [CNT_W-1:0]    CNT_MAX   = '1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        REPORT = 2'd2
    } state_t;

    state_t             state, state_n;
    logic [WORD_W-1:0]  word;
    logic               ovl;
    logic [IDX_W-1:0]   idx;
    logic [PAT_W-1:0]   hist, hn;
    logic [FILL_W-1:0]  fill, fill_inc;
    logic [CNT_W-1:0]   cnt, cnt_inc, count_r;
    logic               hit_r;
    logic               accept, bit_in, match, last_bit;

    always_comb begin
        accept   = (state == IDLE) && bus.in_valid;
        bit_in   = word[idx];
        hn       = {hist[PAT_W-2:0], bit_in};
        fill_inc = (fill == FILL_FULL) ? fill : fill + FILL_W'(1);
        // only a fully populated history may produce a match
        match    = (state == SHIFT) && (hn == PAT) && (fill_inc == FILL_FULL);
        cnt_inc  = (match && (cnt != CNT_MAX)) ? cnt + CNT_W'(1) : cnt;
        last_bit = (idx == '0);
        state_n  = state;
        case (state)
            IDLE:    if (accept)        state_n = SHIFT;
            SHIFT:   if (last_bit)      state_n = REPORT;
            REPORT:  if (bus.out_ready) state_n = IDLE;
            default:                    state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            word    <= '0;
            ovl     <= 1'b0;
            idx     <= '0;
            hist    <= '0;
            fill    <= '0;
            cnt     <= '0;
            count_r <= '0;
            hit_r   <= 1'b0;
        end else begin
            state <= state_n;
            case (state)
                IDLE: begin
                    // flush happens before a same-cycle accept takes effect
                    if (clr) begin
                        hist <= '0;
                        fill <= '0;
                    end
                    if (accept) begin
                        word <= bus.in_data;
                        ovl  <= overlap;
                        cnt  <= '0;
                        idx  <= IDX_W'(WORD_W - 1);
                    end
                end
                SHIFT: begin
                    idx <= idx - IDX_W'(1);
                    cnt <= cnt_inc;
                    if (match && !ovl) begin
                        hist <= '0;
                        fill <= '0;
                    end else begin
                        hist <= hn;
                        fill <= fill_inc;
                    end
                    if (last_bit) begin
                        count_r <= cnt_inc;
                        hit_r   <= (cnt_inc != '0);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == REPORT);
    assign bus.out_count = count_r;
    assign bus.out_hit   = hit_r;
    assign busy          = (state != IDLE);
    assign cstate        = state;
endmodule
